wb_merge_queue: RTL and testbench

- Parametrised successor to the memory-stage write-back select glue.
- Merges register write-back requests from NUM_SRC producers (ALU path, d-cache path, future long-latency units) into one register-file write port.
- Arbitration is fixed-priority; accepted requests are buffered in a DEPTH-entry FIFO and drained one per cycle.
- Sits between the MEM stage and the register file. An optional bypass port lets the hazard controller read pending values.

---
 rtl/wb_merge_queue.sv | 147 ++++++++++++++
 tb/tb_wb_merge_queue.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_merge_queue.sv
// wb_merge_queue: merges register write-back requests from NUM_SRC producers
// into a single register-file write port through a DEPTH-entry FIFO.
// Arbitration is fixed priority (lowest source index wins); granted requests
// that write no register (uses_rw=0 or address 0) are consumed but not queued.
// Optional feature macro: WB_MERGE_BYPASS_EN enables a combinational lookup
// of the newest pending value for a register (o_fwd_hit / o_fwd_data).
module wb_merge_queue #(
  parameter int NUM_SRC        = 2,
  parameter int DEPTH          = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_flush,
  input  logic [NUM_SRC-1:0]                 i_valid,
  input  logic [NUM_SRC-1:0]                 i_uses_rw,
  input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0]  i_rw_addr,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]      i_rw_data,
  output logic [NUM_SRC-1:0]                 o_grant,
  output logic                               o_wb_valid,
  output logic [REG_ADDR_WIDTH-1:0]          o_wb_addr,
  output logic [DATA_WIDTH-1:0]              o_wb_data,
  input  logic                               i_wb_ready,
  output logic                               o_full,
  output logic [$clog2(DEPTH+1)-1:0]         o_count,
  input  logic [REG_ADDR_WIDTH-1:0]          i_fwd_addr,
  output logic                               o_fwd_hit,
  output logic [DATA_WIDTH-1:0]              o_fwd_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Queue control state
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Entry storage; never reset, occupancy is tracked by count_q alone
  logic [REG_ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0]     data_mem [DEPTH];

  logic                      win_found;
  logic [SRC_W-1:0]          win_idx;
  logic [REG_ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0]     win_data;
  logic                      can_accept;
  logic                      push;
  logic                      pop;

  // Head is valid whenever anything is stored; no fall-through from inputs
  assign o_wb_valid = (count_q != '0);
  assign o_full     = (count_q == DEPTH_C);
  assign o_count    = count_q;
  assign o_wb_addr  = o_wb_valid ? addr_mem[head_q] : '0;
  assign o_wb_data  = o_wb_valid ? data_mem[head_q] : '0;

  assign pop        = o_wb_valid & i_wb_ready;
  // A pop in the same cycle frees the slot a full queue needs for the push
  assign can_accept = ~i_flush & (~o_full | pop);

  assign win_addr   = i_rw_addr[win_idx*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
  assign win_data   = i_rw_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
  // Null writes are acknowledged through o_grant but never occupy an entry
  assign push       = win_found & can_accept & i_uses_rw[win_idx] & (win_addr != '0);

  // Fixed-priority arbitration: lowest-index valid source wins
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    o_grant   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!win_found && i_valid[k]) begin
        win_found = 1'b1;
        win_idx   = k[SRC_W-1:0];
      end
    end
    if (win_found) begin
      o_grant[win_idx] = can_accept;
    end
  end

  // Next-state pointers and occupancy; flush overrides push and pop
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Write accepted non-null request into the tail slot
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_q] <= win_addr;
      data_mem[tail_q] <= win_data;
    end
  end

`ifdef WB_MERGE_BYPASS_EN
  logic [PTR_W-1:0] fwd_idx;

  // Scan oldest to newest so the newest matching entry wins
  always_comb begin
    o_fwd_hit  = 1'b0;
    o_fwd_data = '0;
    fwd_idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (i_fwd_addr != '0) &&
          (addr_mem[fwd_idx] == i_fwd_addr)) begin
        o_fwd_hit  = 1'b1;
        o_fwd_data = data_mem[fwd_idx];
      end
    end
  end
`else
  logic unused_fwd_addr;
  assign unused_fwd_addr = ^i_fwd_addr;
  assign o_fwd_hit       = 1'b0;
  assign o_fwd_data      = '0;
`endif

endmodule

// File: tb/tb_wb_merge_queue.sv
// Self-checking bench for wb_merge_queue (default parameters). A queue-based
// model tracks pending entries and predicts every output each cycle; directed
// sequences add literal expectations. Honours WB_MERGE_BYPASS_EN.
module tb_wb_merge_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  valid = '0;
  logic [1:0]  uses = '0;
  logic [9:0]  rw_addr = '0;
  logic [63:0] rw_data = '0;
  logic        ready = 1'b0;
  logic [4:0]  fwd_addr = '0;
  logic [1:0]  grant;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        full;
  logic [2:0]  count;
  logic        fwd_hit;
  logic [31:0] fwd_data;

  int tests = 0;
  int fails = 0;

`ifdef WB_MERGE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  wb_merge_queue #(.NUM_SRC(2), .DEPTH(4), .DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_valid(valid), .i_uses_rw(uses),
    .i_rw_addr(rw_addr), .i_rw_data(rw_data), .o_grant(grant), .o_wb_valid(wb_valid),
    .o_wb_addr(wb_addr), .o_wb_data(wb_data), .i_wb_ready(ready), .o_full(full),
    .o_count(count), .i_fwd_addr(fwd_addr), .o_fwd_hit(fwd_hit), .o_fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, then let them settle
  task automatic set_in(input logic [1:0] v, input logic [1:0] u,
                        input logic [4:0] a0, input logic [31:0] d0,
                        input logic [4:0] a1, input logic [31:0] d1,
                        input logic rdy, input logic fl);
    @(posedge clk);
    #1;
    valid   = v;
    uses    = u;
    rw_addr = {a1, a0};
    rw_data = {d1, d0};
    ready   = rdy;
    flush   = fl;
    #1;
  endtask

  task automatic idle(input logic rdy);
    set_in(2'b00, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, rdy, 1'b0);
  endtask

  // Reference model: pending entries as {addr, data}, oldest at index 0
  logic [36:0] mq[$];

  // Compare every output against the model mid-cycle, then advance the model
  always @(negedge clk) begin : cmp
    int          n;
    int          w;
    logic        acc;
    logic [1:0]  eg;
    logic        eh;
    logic [31:0] efd;
    logic [4:0]  wa;
    logic [31:0] wd;
    if (!rst_n) begin
      mq.delete();
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_full", full, 0);
      chk("rst_wb_addr", wb_addr, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_fwd_hit", fwd_hit, 0);
      chk("rst_fwd_data", fwd_data, 0);
    end else begin
      n   = mq.size();
      w   = valid[0] ? 0 : (valid[1] ? 1 : -1);
      acc = !flush && (n < 4 || (n > 0 && ready));
      eg  = 2'b00;
      if (w >= 0 && acc) eg[w] = 1'b1;
      eh  = 1'b0;
      efd = 32'd0;
      if (BYP && fwd_addr != 5'd0) begin
        for (int i = 0; i < n; i++) begin
          if (mq[i][36:32] == fwd_addr) begin
            eh  = 1'b1;
            efd = mq[i][31:0];
          end
        end
      end
      chk("grant", grant, eg);
      chk("wb_valid", wb_valid, n > 0);
      chk("wb_addr", wb_addr, (n > 0) ? mq[0][36:32] : 5'd0);
      chk("wb_data", wb_data, (n > 0) ? mq[0][31:0] : 32'd0);
      chk("full", full, n == 4);
      chk("count", count, n);
      chk("fwd_hit", fwd_hit, eh);
      chk("fwd_data", fwd_data, efd);
      if (flush) begin
        mq.delete();
      end else begin
        if (n > 0 && ready) void'(mq.pop_front());
        if (eg != 2'b00) begin
          wa = (w == 0) ? rw_addr[4:0] : rw_addr[9:5];
          wd = (w == 0) ? rw_data[31:0] : rw_data[63:32];
          if (uses[w] && wa != 5'd0) mq.push_back({wa, wd});
        end
      end
    end
  end

  logic [1:0]  pend;
  logic [4:0]  pa[2];
  logic [31:0] pd[2];
  logic [1:0]  pu;
  logic [1:0]  g;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Asynchronous reset in the middle of traffic
    for (int i = 1; i <= 3; i++)
      set_in(2'b01, 2'b01, 5'(i), 32'h50 + i, 5'd0, 32'd0, 1'b0, 1'b0);
    idle(1'b0);
    chk("pre_rst_count", count, 3);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_valid", wb_valid, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Fixed priority and acceptance ordering
    set_in(2'b11, 2'b11, 5'd3, 32'h11, 5'd4, 32'h22, 1'b0, 1'b0);
    chk("prio_grant0", grant, 2'b01);
    set_in(2'b10, 2'b11, 5'd3, 32'h11, 5'd4, 32'h22, 1'b0, 1'b0);
    chk("prio_grant1", grant, 2'b10);
    idle(1'b1);
    chk("drain0_addr", wb_addr, 3);
    chk("drain0_data", wb_data, 32'h11);
    idle(1'b1);
    chk("drain1_addr", wb_addr, 4);
    chk("drain1_data", wb_data, 32'h22);
    idle(1'b0);
    chk("drained_count", count, 0);

    // Full boundary, then accept with a same-cycle pop
    for (int i = 1; i <= 4; i++)
      set_in(2'b01, 2'b01, 5'(i), 32'h100 + i, 5'd0, 32'd0, 1'b0, 1'b0);
    set_in(2'b01, 2'b01, 5'd5, 32'h105, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("full_flag", full, 1);
    chk("full_grant", grant, 2'b00);
    ready = 1'b1;
    #1;
    chk("full_pop_grant", grant, 2'b01);
    idle(1'b0);
    chk("full_pop_count", count, 4);
    chk("full_pop_head", wb_addr, 2);
    repeat (4) idle(1'b1);
    idle(1'b0);
    chk("full_drained", count, 0);

    // Null writes are consumed without being queued
    set_in(2'b01, 2'b00, 5'd5, 32'hDEAD, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("null_uses_grant", grant, 2'b01);
    set_in(2'b01, 2'b01, 5'd0, 32'hBEEF, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("null_addr_grant", grant, 2'b01);
    idle(1'b0);
    chk("null_count", count, 0);
    chk("null_valid", wb_valid, 0);

    // Flush with entries pending and a request present
    set_in(2'b01, 2'b01, 5'd6, 32'h66, 5'd0, 32'd0, 1'b0, 1'b0);
    set_in(2'b01, 2'b01, 5'd7, 32'h77, 5'd0, 32'd0, 1'b0, 1'b0);
    set_in(2'b01, 2'b01, 5'd8, 32'h88, 5'd0, 32'd0, 1'b0, 1'b1);
    chk("flush_grant", grant, 2'b00);
    chk("flush_cycle_valid", wb_valid, 1);
    idle(1'b0);
    chk("flush_count", count, 0);
    chk("flush_valid", wb_valid, 0);

    // Bypass lookup returns the newest matching entry
    fwd_addr = 5'd7;
    set_in(2'b01, 2'b01, 5'd7, 32'hA, 5'd0, 32'd0, 1'b0, 1'b0);
    set_in(2'b10, 2'b10, 5'd0, 32'd0, 5'd7, 32'hB, 1'b0, 1'b0);
    idle(1'b0);
    chk("byp_hit", fwd_hit, BYP);
    chk("byp_data", fwd_data, BYP ? 32'hB : 32'h0);
    fwd_addr = 5'd0;
    #1;
    chk("byp_zero_addr", fwd_hit, 0);
    fwd_addr = 5'd7;
    repeat (2) idle(1'b1);
    idle(1'b0);
    chk("byp_after_pop", fwd_hit, 0);

    // Randomised traffic; producers hold a request until it is granted
    pend = '0;
    g    = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int s = 0; s < 2; s++) begin
        if (pend[s] && g[s]) pend[s] = 1'b0;
        if (!pend[s] && ($urandom_range(1, 0) == 1)) begin
          pend[s] = 1'b1;
          pa[s]   = 5'($urandom_range(7, 0));
          pd[s]   = $urandom;
          pu[s]   = ($urandom_range(9, 0) != 0);
        end
      end
      fwd_addr = 5'($urandom_range(7, 0));
      set_in(pend, pu, pa[0], pd[0], pa[1], pd[1], $urandom_range(1, 0) == 1,
             $urandom_range(31, 0) == 0);
      g = grant;
    end
    idle(1'b0);
    @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
